// File: rtl/mac_job_arbiter.sv
// Purpose: round-robin sharing of one signed MAC between two requesters, one job of VEC_LEN pairs at a time.
// Latency: grant to first accept is 2 cycles; result is 1 + MAC latency + 1 cycles after the last accepted pair.
// Backpressure: the non-granted requester sees ready=0; ISSUE stalls on gaps; RESULT holds until res_ready.
module mac_job_arbiter #(
  parameter int VEC_LEN = 4,
  parameter int IN_W    = 10,
  parameter int OUT_W   = 2 * IN_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic signed [IN_W-1:0]  req0_a,
  input  logic signed [IN_W-1:0]  req0_b,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic signed [IN_W-1:0]  req1_a,
  input  logic signed [IN_W-1:0]  req1_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    res_id,
  output logic signed [OUT_W-1:0] res_data,
  output logic signed [IN_W-1:0]  mac_a,
  output logic signed [IN_W-1:0]  mac_b,
  output logic                    mac_valid_in,
  output logic                    mac_clear,
  input  logic signed [OUT_W-1:0] mac_f,
  input  logic                    mac_valid_out
);

  // Counters must be able to hold VEC_LEN itself.
  localparam int CNT_W = (VEC_LEN < 2) ? 1 : $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t           state;
  logic             grant;
  logic             last_grant;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;

  logic             sel_valid;
  logic [IN_W-1:0]  sel_a;
  logic [IN_W-1:0]  sel_b;
  logic             fire;
  logic             last_fire;
  logic             counting;
  logic             last_recv;
  logic             any_req;
  logic             both_req;
  logic             next_grant;

  // Ready is a pure decode of the registered state and grant, so it never depends on valid.
  assign req0_ready = (state == ISSUE) && (grant == 1'b0);
  assign req1_ready = (state == ISSUE) && (grant == 1'b1);

  // The MAC accumulator is held in reset whenever no job owns it.
  assign mac_clear = (state == IDLE) || (state == CLEAR);

  // Select the granted requester's handshake and operands.
  always_comb begin
    sel_valid = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    if (grant) begin
      sel_valid = req1_valid;
      sel_a     = req1_a;
      sel_b     = req1_b;
    end else begin
      sel_valid = req0_valid;
      sel_a     = req0_a;
      sel_b     = req0_b;
    end
  end

  // Fire and receive qualifiers; strobes outside ISSUE/DRAIN are deliberately ignored.
  always_comb begin
    fire      = (state == ISSUE) && sel_valid;
    last_fire = fire && (issue_cnt == LAST_IDX);
    counting  = (state == ISSUE) || (state == DRAIN);
    last_recv = counting && mac_valid_out && (recv_cnt == LAST_IDX);
  end

  // Round-robin: a tie goes to the requester that was not served last.
  always_comb begin
    any_req    = req0_valid || req1_valid;
    both_req   = req0_valid && req1_valid;
    next_grant = both_req ? ~last_grant : req1_valid;
  end

  // Job sequencer with registered MAC and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      mac_a        <= '0;
      mac_b        <= '0;
      mac_valid_in <= 1'b0;
      res_valid    <= 1'b0;
      res_id       <= 1'b0;
      res_data     <= '0;
    end else begin
      mac_valid_in <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= next_grant;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          issue_cnt <= '0;
          recv_cnt  <= '0;
          state     <= ISSUE;
        end
        ISSUE, DRAIN: begin
          if (fire) begin
            mac_a        <= sel_a;
            mac_b        <= sel_b;
            mac_valid_in <= 1'b1;
            issue_cnt    <= issue_cnt + CNT_ONE;
            if (last_fire) begin
              state <= DRAIN;
            end
          end
          if (mac_valid_out) begin
            recv_cnt <= recv_cnt + CNT_ONE;
          end
          // The final strobe always trails the final fire, so this never races the DRAIN move.
          if (last_recv) begin
            res_data  <= mac_f;
            res_id    <= grant;
            res_valid <= 1'b1;
            state     <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Bench for mac_job_arbiter with a 1-cycle signed MAC model attached.
// Table rows run whole jobs; hand sequences cover stall, gap and mid-job reset.
// Expected results are queued at stimulus time and popped on each result handshake.
module tb_mac_job_arbiter;

  logic               clk;
  logic               reset;
  logic               req0_valid, req0_ready, req1_valid, req1_ready;
  logic signed [9:0]  req0_a, req0_b, req1_a, req1_b;
  logic               res_valid, res_ready, res_id;
  logic signed [19:0] res_data;
  logic signed [9:0]  mac_a, mac_b;
  logic               mac_valid_in, mac_clear;
  logic signed [19:0] mac_f;
  logic               mac_valid_out;

  mac_job_arbiter #(.VEC_LEN(4), .IN_W(10), .OUT_W(20)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
    .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_valid_in), .mac_clear(mac_clear),
    .mac_f(mac_f), .mac_valid_out(mac_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model: synchronous clear, one-cycle latency, 20-bit wrapping accumulate.
  logic signed [19:0] mac_acc = '0;
  logic               mac_vo  = 1'b0;
  assign mac_f         = mac_acc;
  assign mac_valid_out = mac_vo;
  always @(posedge clk) begin
    if (mac_clear) begin
      mac_acc <= '0;
      mac_vo  <= 1'b0;
    end else begin
      mac_vo <= mac_valid_in;
      if (mac_valid_in) mac_acc <= mac_acc + ($signed(mac_a) * $signed(mac_b));
    end
  end

  typedef struct {
    bit  id;
    int  data;
  } exp_t;

  typedef struct {
    bit               use0;
    bit               use1;
    logic [3:0][9:0]  a0;
    logic [3:0][9:0]  b0;
    logic [3:0][9:0]  a1;
    logic [3:0][9:0]  b1;
    int               exp0;
    int               exp1;
    bit               first;
  } row_t;

  exp_t sb[$];
  row_t rows[6];
  int   vectors = 0;
  int   miscompares = 0;
  int   fw0, fw1;
  bit   rec = 1'b0;
  bit   hist[$];
  logic prev_clear = 1'b1;
  logic prev_r0 = 1'b0;
  logic prev_r1 = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0][9:0] pk(input int x0, input int x1, input int x2, input int x3);
    logic [3:0][9:0] p;
    p[0] = 10'(x0);
    p[1] = 10'(x1);
    p[2] = 10'(x2);
    p[3] = 10'(x3);
    return p;
  endfunction

  task automatic push(input bit id, input int data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic drive(input bit id, input bit v, input logic [9:0] a, input logic [9:0] b);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mac_clear"},    int'(mac_clear), 1);
    chk({tag, "_mac_valid_in"}, int'(mac_valid_in), 0);
    chk({tag, "_mac_a"},        int'(mac_a), 0);
    chk({tag, "_mac_b"},        int'(mac_b), 0);
    chk({tag, "_res_valid"},    int'(res_valid), 0);
    chk({tag, "_res_id"},       int'(res_id), 0);
    chk({tag, "_res_data"},     int'(res_data), 0);
    chk({tag, "_req0_ready"},   int'(req0_ready), 0);
    chk({tag, "_req1_ready"},   int'(req1_ready), 0);
  endtask

  // Send four pairs; optional valid gap after the 2nd accepted pair. Reports cycles to first accept.
  task automatic send(input bit id, input logic [3:0][9:0] a, input logic [3:0][9:0] b,
                      input int gap_len, output int first_wait);
    int i;
    int it;
    bit rdy;
    i = 0;
    it = 0;
    first_wait = -1;
    while (i < 4 && it < 400) begin
      @(negedge clk);
      drive(id, 1'b1, a[i], b[i]);
      #1;
      rdy = id ? req1_ready : req0_ready;
      if (rdy) begin
        if (first_wait < 0) first_wait = it;
        i++;
        if (i == 2 && gap_len > 0) begin
          for (int g = 0; g < gap_len; g++) begin
            @(negedge clk);
            drive(id, 1'b0, 10'd0, 10'd0);
            #1;
            chk("ready_in_gap", int'(id ? req1_ready : req0_ready), 1);
          end
        end
      end
      it++;
    end
    chk("send_done", i, 4);
    @(negedge clk);
    drive(id, 1'b0, 10'd0, 10'd0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Result scoreboard and per-cycle invariants, sampled late in the low clock phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: id %0d data %0d, no result expected", res_id, res_data);
          end else begin
            e = sb.pop_front();
            chk("res_id", int'(res_id), int'(e.id));
            chk("res_data", int'(res_data), e.data);
          end
        end
        chk("ready_exclusive", int'(req0_ready && req1_ready), 0);
        if ((req0_ready && !prev_r0) || (req1_ready && !prev_r1)) begin
          chk("clear_before_issue", int'(prev_clear), 1);
          chk("clear_off_in_issue", int'(mac_clear), 0);
        end
        if (rec) hist.push_back(mac_valid_in);
      end
      prev_clear = mac_clear;
      prev_r0    = req0_ready;
      prev_r1    = req1_ready;
    end
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    rows[0] = '{1'b1, 1'b1, pk(1, 3, 5, 7), pk(2, 4, 6, 8), pk(-1, -1, -1, -1), pk(10, 10, 10, 10), 100, -40, 1'b0};
    rows[1] = '{1'b1, 1'b1, pk(2, 2, 2, 2), pk(3, 3, 3, 3), pk(-512, -512, -512, -512), pk(-512, -512, -512, -512), 24, 0, 1'b0};
    rows[2] = '{1'b0, 1'b1, pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(3, 100, -512, 0), pk(-7, 100, 511, 5), 0, -251653, 1'b1};
    rows[3] = '{1'b1, 1'b1, pk(-512, -512, -512, -512), pk(-512, -512, -512, -512), pk(1, 1, 1, 1), pk(1, 1, 1, 1), 0, 4, 1'b0};
    rows[4] = '{1'b1, 1'b0, pk(511, 511, 511, 511), pk(511, 511, 511, 511), pk(0, 0, 0, 0), pk(0, 0, 0, 0), -4092, 0, 1'b0};
    rows[5] = '{1'b1, 1'b1, pk(1, 3, 5, 7), pk(2, 4, 6, 8), pk(-1, -1, -1, -1), pk(10, 10, 10, 10), 100, -40, 1'b1};

    reset = 1'b0;
    res_ready = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 10'd0);
    drive(1'b1, 1'b0, 10'd0, 10'd0);
    repeat (3) @(negedge clk);
    #1 chk_reset("por");
    @(negedge clk);
    reset = 1'b1;

    // Table-driven jobs; grant order carries over from row to row.
    for (int r = 0; r < 6; r++) begin
      if (rows[r].first == 1'b0) begin
        if (rows[r].use0) push(1'b0, rows[r].exp0);
        if (rows[r].use1) push(1'b1, rows[r].exp1);
      end else begin
        if (rows[r].use1) push(1'b1, rows[r].exp1);
        if (rows[r].use0) push(1'b0, rows[r].exp0);
      end
      fw0 = -1;
      fw1 = -1;
      fork
        begin
          if (rows[r].use0) send(1'b0, rows[r].a0, rows[r].b0, 0, fw0);
        end
        begin
          if (rows[r].use1) send(1'b1, rows[r].a1, rows[r].b1, 0, fw1);
        end
      join
      chk("grant_latency", rows[r].first ? fw1 : fw0, 2);
      wait_drain(200);
    end

    // Result held under backpressure while req1 waits.
    res_ready = 1'b0;
    push(1'b0, 100);
    push(1'b1, 4);
    fork
      send(1'b0, pk(1, 3, 5, 7), pk(2, 4, 6, 8), 0, fw0);
      begin
        repeat (4) @(negedge clk);
        send(1'b1, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 0, fw1);
      end
      begin : stall_chk
        int n;
        n = 0;
        while (n < 100) begin
          @(negedge clk);
          #2;
          if (res_valid) break;
          n++;
        end
        chk("stall_reach", int'(res_valid), 1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          #2;
          chk("stall_res_valid", int'(res_valid), 1);
          chk("stall_res_data", int'(res_data), 100);
          chk("stall_res_id", int'(res_id), 0);
          chk("stall_req0_ready", int'(req0_ready), 0);
          chk("stall_req1_ready", int'(req1_ready), 0);
          chk("stall_mac_valid_in", int'(mac_valid_in), 0);
          chk("stall_req1_waiting", int'(req1_valid), 1);
        end
        @(negedge clk);
        res_ready = 1'b1;
      end
    join
    wait_drain(200);

    // Requester gap: 3-cycle hole in mac_valid_in, result unchanged.
    begin : gap_seq
      int idx[$];
      hist.delete();
      rec = 1'b1;
      push(1'b0, 100);
      send(1'b0, pk(1, 3, 5, 7), pk(2, 4, 6, 8), 3, fw0);
      wait_drain(200);
      rec = 1'b0;
      foreach (hist[k]) if (hist[k]) idx.push_back(k);
      chk("gap_pulses", idx.size(), 4);
      if (idx.size() == 4) begin
        chk("gap_pre", idx[1] - idx[0], 1);
        chk("gap_len", idx[2] - idx[1] - 1, 3);
        chk("gap_post", idx[3] - idx[2], 1);
      end
    end

    // Reset after the 2nd accepted pair abandons the job.
    begin : rst_seq
      int fires;
      int n;
      fires = 0;
      n = 0;
      while (fires < 2 && n < 50) begin
        @(negedge clk);
        drive(1'b0, 1'b1, 10'(fires + 5), 10'd3);
        #1;
        if (req0_ready) fires++;
        n++;
      end
      chk("pre_reset_fires", fires, 2);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 1'b0, 10'd0, 10'd0);
      #1 chk_reset("mid_job");
      @(negedge clk);
      #1 chk_reset("mid_job_hold");
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      push(1'b0, 4);
      send(1'b0, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 0, fw0);
      chk("post_reset_latency", fw0, 2);
      wait_drain(200);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
